// File: rtl/tx_char_scheduler.sv
// SpaceWire TX character scheduler: TIME > FCT > NCHAR > NULL arbitration, ping-pong
// drain of the two N-Char buffers and transmit credit. TX_TIMECODE_EN enables the Time-Code path.
module tx_char_scheduler #(
  parameter int CREDIT_MAX   = 56,
  parameter int FCT_PEND_MAX = 7
) (
  input  logic       pclk_tx,
  input  logic       reset_tx,
  input  logic [1:0] link_mode,
  input  logic       tcode_rdy_trnsp,
  input  logic [7:0] tx_tcode_in,
  input  logic       process_data,
  input  logic       process_data_0,
  input  logic [8:0] tx_data_in,
  input  logic [8:0] tx_data_in_0,
  input  logic       fct_rx,
  input  logic       fct_req,
  input  logic       char_ready,
  output logic       get_data,
  output logic       get_data_0,
  output logic       fct_counter_p,
  output logic       char_valid,
  output logic [1:0] char_type,
  output logic [8:0] char_data,
  output logic       credit_error,
  output logic       tcode_overrun
);

  // state | meaning
  // OFF   | link disabled; credit, FCTs owed, Time-Code and buffer select cleared
  // ARB   | pick the next character by priority, gated by link_mode
  // SEND  | character presented on char_*, held until char_ready
  typedef enum logic [1:0] {OFF, ARB, SEND} state_t;

  localparam logic [1:0] TYPE_NULL  = 2'b00;
  localparam logic [1:0] TYPE_FCT   = 2'b01;
  localparam logic [1:0] TYPE_TIME  = 2'b10;
  localparam logic [1:0] TYPE_NCHAR = 2'b11;
  localparam logic [5:0] CREDIT_LIM = 6'(CREDIT_MAX - 8);
  localparam logic [3:0] PEND_MAX   = 4'(FCT_PEND_MAX);

  state_t     state;
  logic [5:0] credit;
  logic [2:0] fct_pend;
  logic       sel;
  logic       tc_pend;
  logic [7:0] tc_val;

  logic       accept;
  logic       acc_fct;
  logic       acc_nchar;
  logic [5:0] credit_base;
  logic [3:0] fct_sum;
  logic [2:0] fct_next;
  logic       buf_valid;
  logic [8:0] buf_data;

  assign accept      = (state == SEND) && char_ready;
  assign acc_fct     = accept && (char_type == TYPE_FCT);
  assign acc_nchar   = accept && (char_type == TYPE_NCHAR);
  // overflow test is made on the credit left after this cycle's N-Char accept
  assign credit_base = credit - {5'd0, acc_nchar};
  assign buf_valid   = sel ? process_data_0 : process_data;
  assign buf_data    = sel ? tx_data_in_0 : tx_data_in;
  assign fct_counter_p = (credit != 6'd0);

  always_comb begin
    fct_sum  = {1'b0, fct_pend} + {3'd0, fct_req} - {3'd0, acc_fct};
    fct_next = fct_sum[2:0];
    if (fct_sum > PEND_MAX) fct_next = PEND_MAX[2:0];
  end

`ifdef TX_TIMECODE_EN
  logic acc_time;
  assign acc_time = accept && (char_type == TYPE_TIME);

  always_ff @(posedge pclk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      tc_pend       <= 1'b0;
      tc_val        <= 8'h00;
      tcode_overrun <= 1'b0;
    end else if (link_mode == 2'b00) begin
      tc_pend       <= 1'b0;
      tcode_overrun <= 1'b0;
    end else begin
      // a pulse landing on the TIME accept replaces a value already sent, nothing is lost
      tcode_overrun <= tcode_rdy_trnsp && tc_pend && !acc_time;
      if (tcode_rdy_trnsp) begin
        tc_pend <= 1'b1;
        tc_val  <= tx_tcode_in;
      end else if (acc_time) begin
        tc_pend <= 1'b0;
      end
    end
  end
`else
  logic unused_tc;
  assign unused_tc     = ^{tcode_rdy_trnsp, tx_tcode_in};
  assign tc_pend       = 1'b0;
  assign tc_val        = 8'h00;
  assign tcode_overrun = 1'b0;
`endif

  always_ff @(posedge pclk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      state        <= OFF;
      credit       <= 6'd0;
      fct_pend     <= 3'd0;
      sel          <= 1'b0;
      char_valid   <= 1'b0;
      char_type    <= TYPE_NULL;
      char_data    <= 9'h000;
      get_data     <= 1'b0;
      get_data_0   <= 1'b0;
      credit_error <= 1'b0;
    end else if (link_mode == 2'b00) begin
      state        <= OFF;
      credit       <= 6'd0;
      fct_pend     <= 3'd0;
      sel          <= 1'b0;
      char_valid   <= 1'b0;
      char_type    <= TYPE_NULL;
      char_data    <= 9'h000;
      get_data     <= 1'b0;
      get_data_0   <= 1'b0;
      credit_error <= 1'b0;
    end else begin
      get_data     <= acc_nchar && !sel;
      get_data_0   <= acc_nchar && sel;
      if (acc_nchar) sel <= !sel;
      fct_pend     <= fct_next;
      credit_error <= 1'b0;
      if (fct_rx && (credit_base > CREDIT_LIM)) begin
        credit       <= credit_base;
        credit_error <= 1'b1;
      end else if (fct_rx) begin
        credit <= credit_base + 6'd8;
      end else begin
        credit <= credit_base;
      end

      case (state)
        OFF: state <= ARB;
        ARB: begin
          state      <= SEND;
          char_valid <= 1'b1;
          if ((link_mode == 2'b11) && tc_pend) begin
            char_type <= TYPE_TIME;
            char_data <= {1'b0, tc_val};
          end else if (link_mode[1] && (fct_pend != 3'd0)) begin
            char_type <= TYPE_FCT;
            char_data <= 9'h000;
          end else if ((link_mode == 2'b11) && (credit != 6'd0) && buf_valid) begin
            char_type <= TYPE_NCHAR;
            char_data <= buf_data;
          end else begin
            char_type <= TYPE_NULL;
            char_data <= 9'h000;
          end
        end
        SEND: begin
          if (char_ready) begin
            state      <= ARB;
            char_valid <= 1'b0;
          end
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_char_scheduler.sv
// Self-checking bench for tx_char_scheduler: vector table, directed corner sequences and
// randomized traffic against a character-level reference model. Honors TX_TIMECODE_EN.
module tb_tx_char_scheduler;

  localparam int CREDIT_MAX   = 56;
  localparam int FCT_PEND_MAX = 7;
  localparam int T_NULL = 0, T_FCT = 1, T_TIME = 2, T_NCHAR = 3;

  logic       pclk_tx = 1'b0;
  logic       reset_tx;
  logic [1:0] link_mode;
  logic       tcode_rdy_trnsp;
  logic [7:0] tx_tcode_in;
  logic       process_data, process_data_0;
  logic [8:0] tx_data_in, tx_data_in_0;
  logic       fct_rx, fct_req, char_ready;
  logic       get_data, get_data_0, fct_counter_p, char_valid;
  logic [1:0] char_type;
  logic [8:0] char_data;
  logic       credit_error, tcode_overrun;

  tx_char_scheduler #(.CREDIT_MAX(CREDIT_MAX), .FCT_PEND_MAX(FCT_PEND_MAX)) dut (
    .pclk_tx(pclk_tx), .reset_tx(reset_tx), .link_mode(link_mode),
    .tcode_rdy_trnsp(tcode_rdy_trnsp), .tx_tcode_in(tx_tcode_in),
    .process_data(process_data), .process_data_0(process_data_0),
    .tx_data_in(tx_data_in), .tx_data_in_0(tx_data_in_0),
    .fct_rx(fct_rx), .fct_req(fct_req), .char_ready(char_ready),
    .get_data(get_data), .get_data_0(get_data_0), .fct_counter_p(fct_counter_p),
    .char_valid(char_valid), .char_type(char_type), .char_data(char_data),
    .credit_error(credit_error), .tcode_overrun(tcode_overrun)
  );

  always #5 pclk_tx = ~pclk_tx;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk_tx);
    #1;
  endtask

  task automatic clear_inputs();
    link_mode = 2'b00; tcode_rdy_trnsp = 1'b0; tx_tcode_in = 8'h00;
    process_data = 1'b0; process_data_0 = 1'b0; tx_data_in = 9'h000; tx_data_in_0 = 9'h000;
    fct_rx = 1'b0; fct_req = 1'b0; char_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_tx = 1'b1;
    tick();
    tick();
    reset_tx = 1'b0;
  endtask

  // ---------------- character collection helpers ----------------
  int ct[64], cd[64];
  bit cg0[64], cg1[64];

  task automatic hold();
    int n = 0;
    char_ready = 1'b0;
    while (!char_valid && n < 20) begin tick(); n++; end
    if (!char_valid) begin
      checks++; errors++;
      $display("FAIL hold: no char_valid within 20 cycles");
    end
  endtask

  task automatic collect(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int n = 0;
      ct[i] = -1; cd[i] = 0; cg0[i] = 1'b0; cg1[i] = 1'b0;
      char_ready = 1'b1;
      while (!char_valid && n < 20) begin tick(); n++; end
      if (!char_valid) begin
        checks++; errors++;
        $display("FAIL collect[%0d]: no char_valid within 20 cycles", i);
      end else begin
        ct[i] = int'(char_type);
        cd[i] = int'(char_data);
        tick();
        cg0[i] = get_data;
        cg1[i] = get_data_0;
      end
    end
  endtask

  function automatic int count_type(input int cnt, input int t);
    int c = 0;
    for (int i = 0; i < cnt; i++) if (ct[i] == t) c++;
    return c;
  endfunction

  // ---------------- reference model (character slots) ----------------
  bit m_off, m_busy, m_g0, m_g1, m_cerr, m_tovr, m_tcp;
  int m_type, m_data, m_credit, m_pend, m_sel, m_tcv;

  task automatic model_reset();
    m_off = 1; m_busy = 0; m_credit = 0; m_pend = 0; m_sel = 0; m_tcp = 0; m_tcv = 0;
    m_type = 0; m_data = 0; m_g0 = 0; m_g1 = 0; m_cerr = 0; m_tovr = 0;
  endtask

  task automatic model_step();
    bit acc;
    int at, c;
    m_g0 = 0; m_g1 = 0; m_cerr = 0; m_tovr = 0;
    if (link_mode == 2'b00) begin
      m_off = 1; m_busy = 0; m_credit = 0; m_pend = 0; m_sel = 0; m_tcp = 0;
      return;
    end
    acc = m_busy && char_ready;
    at  = m_type;
    if (m_off) m_off = 0;
    else if (!m_busy) begin
      m_busy = 1;
      if (link_mode == 2'b11 && m_tcp) begin
        m_type = T_TIME; m_data = m_tcv;
      end else if (link_mode >= 2'b10 && m_pend > 0) begin
        m_type = T_FCT; m_data = 0;
      end else if (link_mode == 2'b11 && m_credit > 0 &&
                   ((m_sel == 0) ? process_data : process_data_0)) begin
        m_type = T_NCHAR;
        m_data = (m_sel == 0) ? int'(tx_data_in) : int'(tx_data_in_0);
      end else begin
        m_type = T_NULL; m_data = 0;
      end
    end else if (acc) m_busy = 0;

    c = m_credit;
    if (acc && at == T_NCHAR) begin
      c = c - 1;
      if (m_sel == 0) m_g0 = 1; else m_g1 = 1;
      m_sel = 1 - m_sel;
    end
    if (fct_rx) begin
      if (c + 8 > CREDIT_MAX) m_cerr = 1;
      else c = c + 8;
    end
    m_credit = c;
    m_pend = m_pend + int'(fct_req) - ((acc && at == T_FCT) ? 1 : 0);
    if (m_pend > FCT_PEND_MAX) m_pend = FCT_PEND_MAX;
`ifdef TX_TIMECODE_EN
    if (tcode_rdy_trnsp) begin
      m_tovr = m_tcp && !(acc && at == T_TIME);
      m_tcp = 1;
      m_tcv = int'(tx_tcode_in);
    end else if (acc && at == T_TIME) m_tcp = 0;
`endif
  endtask

  task automatic model_compare();
    chk("rnd char_valid", int'(char_valid), int'(m_busy));
    if (m_busy) begin
      chk("rnd char_type", int'(char_type), m_type);
      chk("rnd char_data", int'(char_data), m_data);
    end
    chk("rnd get_data", int'(get_data), int'(m_g0));
    chk("rnd get_data_0", int'(get_data_0), int'(m_g1));
    chk("rnd credit_error", int'(credit_error), int'(m_cerr));
    chk("rnd tcode_overrun", int'(tcode_overrun), int'(m_tovr));
    chk("rnd fct_counter_p", int'(fct_counter_p), (m_credit > 0) ? 1 : 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] mode;
    bit req, rx, rdy;
    bit ev;
    int et;
    bit ec;
  } vec_t;
  vec_t tbl[17];

  initial begin
    tbl[0]  = '{2'b01, 0, 0, 1, 0, 0,       0};
    tbl[1]  = '{2'b01, 0, 0, 1, 1, T_NULL,  0};
    tbl[2]  = '{2'b01, 0, 0, 1, 0, 0,       0};
    tbl[3]  = '{2'b01, 0, 0, 1, 1, T_NULL,  0};
    tbl[4]  = '{2'b10, 1, 0, 1, 0, 0,       0};
    tbl[5]  = '{2'b10, 0, 0, 1, 1, T_FCT,   0};
    tbl[6]  = '{2'b10, 0, 0, 0, 1, T_FCT,   0};
    tbl[7]  = '{2'b10, 1, 0, 1, 0, 0,       0};
    tbl[8]  = '{2'b10, 0, 0, 1, 1, T_FCT,   0};
    tbl[9]  = '{2'b10, 0, 0, 1, 0, 0,       0};
    tbl[10] = '{2'b10, 0, 0, 1, 1, T_NULL,  0};
    tbl[11] = '{2'b10, 0, 1, 0, 1, T_NULL,  1};
    tbl[12] = '{2'b11, 0, 0, 1, 0, 0,       1};
    tbl[13] = '{2'b11, 0, 0, 1, 1, T_NULL,  1};
    tbl[14] = '{2'b00, 0, 0, 1, 0, 0,       0};
    tbl[15] = '{2'b01, 0, 0, 1, 0, 0,       0};
    tbl[16] = '{2'b01, 0, 0, 1, 1, T_NULL,  0};

    // reset state
    do_reset();
    chk("reset char_valid", int'(char_valid), 0);
    chk("reset char_type", int'(char_type), 0);
    chk("reset char_data", int'(char_data), 0);
    chk("reset get_data", int'({get_data, get_data_0}), 0);
    chk("reset fct_counter_p", int'(fct_counter_p), 0);
    chk("reset errors", int'({credit_error, tcode_overrun}), 0);

    for (int i = 0; i < 17; i++) begin
      link_mode = tbl[i].mode; fct_req = tbl[i].req; fct_rx = tbl[i].rx; char_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec[%0d] char_valid", i), int'(char_valid), int'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("vec[%0d] char_type", i), int'(char_type), tbl[i].et);
      chk($sformatf("vec[%0d] fct_counter_p", i), int'(fct_counter_p), int'(tbl[i].ec));
      chk($sformatf("vec[%0d] quiet", i),
          int'({get_data, get_data_0, credit_error, tcode_overrun}), 0);
    end
    fct_req = 0; fct_rx = 0;

    // FCTs owed: 3 requests, then 8 requests saturating at 7
    do_reset();
    link_mode = 2'b10;
    hold();
    for (int i = 0; i < 3; i++) begin fct_req = 1; tick(); end
    fct_req = 0;
    collect(5);
    chk("fct3 count", count_type(5, T_FCT), 3);
    chk("fct3 then null", ct[4], T_NULL);
    hold();
    for (int i = 0; i < 8; i++) begin fct_req = 1; tick(); end
    fct_req = 0;
    collect(9);
    chk("fct_sat count", count_type(9, T_FCT), 7);
    chk("fct_sat then null", ct[8], T_NULL);

    // ping-pong drain of 8 credits
    do_reset();
    link_mode = 2'b11;
    process_data = 1; process_data_0 = 1; tx_data_in = 9'h041; tx_data_in_0 = 9'h142;
    hold();
    fct_rx = 1; tick(); fct_rx = 0;
    chk("pp fct_counter_p set", int'(fct_counter_p), 1);
    collect(10);
    chk("pp first null", ct[0], T_NULL);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("pp[%0d] type", i), ct[i], T_NCHAR);
      chk($sformatf("pp[%0d] data", i), cd[i], (i % 2 == 1) ? 'h041 : 'h142);
      chk($sformatf("pp[%0d] get_data", i), int'(cg0[i]), (i % 2 == 1) ? 1 : 0);
      chk($sformatf("pp[%0d] get_data_0", i), int'(cg1[i]), (i % 2 == 1) ? 0 : 1);
    end
    chk("pp trailing null", ct[9], T_NULL);
    chk("pp fct_counter_p cleared", int'(fct_counter_p), 0);

    // credit overflow at 56
    do_reset();
    link_mode = 2'b10; char_ready = 1;
    for (int i = 0; i < 7; i++) begin
      fct_rx = 1; tick();
      chk($sformatf("fill[%0d] credit_error", i), int'(credit_error), 0);
    end
    fct_rx = 1; tick(); fct_rx = 0;
    chk("overflow credit_error", int'(credit_error), 1);
    tick();
    chk("overflow pulse width", int'(credit_error), 0);
    link_mode = 2'b11;
    process_data = 1; process_data_0 = 1; tx_data_in = 9'h041; tx_data_in_0 = 9'h142;
    collect(60);
    chk("overflow drain count", count_type(60, T_NCHAR), 56);

    // fct_rx coinciding with NCHAR accept
    do_reset();
    link_mode = 2'b11;
    for (int i = 0; i < 7; i++) begin fct_rx = 1; tick(); end
    fct_rx = 0;
    hold();
    process_data = 1; process_data_0 = 1; tx_data_in = 9'h041; tx_data_in_0 = 9'h142;
    collect(1);
    hold();
    chk("coinc held type 56", int'(char_type), T_NCHAR);
    char_ready = 1; fct_rx = 1; tick(); fct_rx = 0;
    chk("coinc 56-1+8 rejected", int'(credit_error), 1);
    collect(7);
    chk("coinc drain 7", count_type(7, T_NCHAR), 7);
    hold();
    chk("coinc held type 48", int'(char_type), T_NCHAR);
    char_ready = 1; fct_rx = 1; tick(); fct_rx = 0;
    chk("coinc 48+7 accepted", int'(credit_error), 0);
    collect(60);
    chk("coinc drain 55", count_type(60, T_NCHAR), 55);

    // Time-Code priority and overrun
    do_reset();
    link_mode = 2'b11;
    process_data = 1; process_data_0 = 1; tx_data_in = 9'h041; tx_data_in_0 = 9'h142;
    hold();
    tcode_rdy_trnsp = 1; tx_tcode_in = 8'h2A; fct_req = 1; fct_rx = 1;
    tick();
    tcode_rdy_trnsp = 0; fct_req = 0; fct_rx = 0;
    chk("tc first overrun", int'(tcode_overrun), 0);
    collect(4);
    chk("tc seq[0]", ct[0], T_NULL);
`ifdef TX_TIMECODE_EN
    chk("tc seq[1] type", ct[1], T_TIME);
    chk("tc seq[1] data", cd[1], 'h02A);
    chk("tc seq[2] type", ct[2], T_FCT);
    chk("tc seq[3] type", ct[3], T_NCHAR);
    chk("tc seq[3] data", cd[3], 'h041);
`else
    chk("tc seq[1] type", ct[1], T_FCT);
    chk("tc seq[2] type", ct[2], T_NCHAR);
    chk("tc seq[3] type", ct[3], T_NCHAR);
    chk("tc seq[3] data", cd[3], 'h142);
`endif
    hold();
    tcode_rdy_trnsp = 1; tx_tcode_in = 8'h11; tick();
    chk("tc overrun after 1st", int'(tcode_overrun), 0);
    tx_tcode_in = 8'h22; tick();
    tcode_rdy_trnsp = 0;
`ifdef TX_TIMECODE_EN
    chk("tc overrun after 2nd", int'(tcode_overrun), 1);
`else
    chk("tc overrun after 2nd", int'(tcode_overrun), 0);
`endif
    tick();
    chk("tc overrun pulse width", int'(tcode_overrun), 0);
    collect(2);
    chk("tc2 held type", ct[0], T_NCHAR);
`ifdef TX_TIMECODE_EN
    chk("tc2 type", ct[1], T_TIME);
    chk("tc2 data", cd[1], 'h022);
`else
    chk("tc2 type", ct[1], T_NCHAR);
`endif

    // link_mode to 00 mid-SEND
    do_reset();
    link_mode = 2'b11;
    process_data = 1; process_data_0 = 1; tx_data_in = 9'h041; tx_data_in_0 = 9'h142;
    hold();
    fct_rx = 1; fct_req = 1; tick(); fct_rx = 0; fct_req = 0;
    collect(3);
    chk("off pre type", ct[2], T_NCHAR);
    chk("off pre data", cd[2], 'h041);
    hold();
    chk("off held type", int'(char_type), T_NCHAR);
    link_mode = 2'b00; tick();
    chk("off char_valid", int'(char_valid), 0);
    chk("off fct_counter_p", int'(fct_counter_p), 0);
    link_mode = 2'b11; fct_req = 1; tick(); fct_req = 0;
    collect(3);
    chk("off reentry fct count", count_type(3, T_FCT), 1);
    chk("off reentry no nchar", count_type(3, T_NCHAR), 0);
    fct_rx = 1; tick(); fct_rx = 0;
    collect(4);
    begin
      int k = -1;
      for (int i = 0; i < 4; i++) if (k < 0 && ct[i] == T_NCHAR) k = i;
      chk("off reentry nchar found", (k >= 0) ? 1 : 0, 1);
      if (k >= 0) begin
        chk("off reentry buffer0 data", cd[k], 'h041);
        chk("off reentry get_data", int'(cg0[k]), 1);
      end
    end

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    link_mode = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        int r = int'($urandom_range(0, 9));
        link_mode = (r < 6) ? 2'b11 : (r == 6) ? 2'b00 : (r == 7) ? 2'b01 : 2'b10;
      end
      fct_req         = ($urandom_range(0, 5) == 0);
      fct_rx          = ($urandom_range(0, 11) == 0);
      tcode_rdy_trnsp = ($urandom_range(0, 15) == 0);
      tx_tcode_in     = 8'($urandom);
      process_data    = ($urandom_range(0, 3) != 0);
      process_data_0  = ($urandom_range(0, 3) != 0);
      tx_data_in      = 9'($urandom);
      tx_data_in_0    = 9'($urandom);
      char_ready      = ($urandom_range(0, 3) != 0);
      model_step();
      tick();
      model_compare();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
